temp_sensor_reader: RTL and testbench
=====================================

# temp_sensor_reader

Serial front end feeding the thermal monitor. Periodically reads a 16-bit frame from an SPI temperature sensor (13-bit two's-complement, 0.0625 °C LSB). Converts each reading to the monitor's unsigned fixed-point format: `temp` integer degrees plus `temp_frac` sixteenths. Saturates readings to the monitor's 0.0–63.9375 °C range and pulses `valid` on each update.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period; minimum 2.
- `SAMPLE_PERIOD`, default 1000000: `clk` cycles between conversion starts; must be ≥ 34*CLK_DIV+2.
- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `cs_n` output, 1 bit: sensor chip select, active low.
- `sclk` output, 1 bit: SPI clock; idles low (CPOL=0, CPHA=0).
- `miso` input, 1 bit: sensor data, MSB first; sensor changes it on falling `sclk`.
- `temp` output, 6 bits: integer °C, saturated.
- `temp_frac` output, 4 bits: fractional °C in 1/16 units.
- `valid` output, 1 bit: one-cycle pulse when `temp`/`temp_frac` update.
- `fault` output, 1 bit: sensor fault flag; constant 0 unless `TSR_FAULT_DETECT_EN` is defined.

## Operation
- FSM states:
  - IDLE: waits for the period counter to reach 0, then goes to SETUP.
  - SETUP: `cs_n` low, `sclk` low for CLK_DIV cycles.
  - SHIFT: 16 `sclk` periods, each CLK_DIV low then CLK_DIV high. `miso` is sampled into the shift register in the `clk` cycle in which `sclk` rises. Bit counter runs 15→0.
  - HOLD: `sclk` low, `cs_n` still low for CLK_DIV cycles.
  - UPDATE: `cs_n` high; output registers load; `valid`=1 for this cycle only; then IDLE.
- Period counter:
  - Free-running 0..SAMPLE_PERIOD-1, wraps to 0.
  - Starts at 0 out of reset, so the first conversion begins the cycle after reset deasserts.
  - Never stalls.
- Conversion: raw = frame[15:3], signed 13-bit; frame[2:0] ignored.
  - raw < 0: `temp`=0, `temp_frac`=0.
  - raw[11:4] > 63: `temp`=63, `temp_frac`=15.
  - Otherwise: `temp`=raw[9:4], `temp_frac`=raw[3:0].
- Outputs hold their last values between UPDATE cycles.

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `temp`=0, `temp_frac`=0, `valid`=0, `fault`=0. FSM in IDLE, period counter 0, shift register 0.
- Reset asserted mid-frame: frame is aborted and `cs_n`=1 at the next edge. No `valid` pulse. Outputs return to reset values.
- `cs_n` low to first `sclk` rise: 2*CLK_DIV cycles. Last `sclk` fall to `cs_n` high: CLK_DIV cycles.
- Latency, conversion start (leaving IDLE) to `valid`: 34*CLK_DIV+1 cycles. That is 137 cycles at CLK_DIV=4.
- Exactly 16 `sclk` rising edges per frame; none outside SHIFT.
- Period counter reaching 0 while a frame is in progress cannot occur, given the SAMPLE_PERIOD constraint; no queuing.

## Configuration
- `TSR_FAULT_DETECT_EN` defined:
  - A frame of 16'hFFFF (open/floating `miso`) or 16'h0000 (stuck low) sets `fault`=1 and forces `temp`=63, `temp_frac`=15. The forced 63.9375 °C drives the monitor to emergency (fail-safe).
  - `valid` still pulses.
  - The next good frame clears `fault` in its UPDATE cycle.
- Not defined:
  - `fault` is tied 0. Fault-detection logic is absent.
  - 16'hFFFF converts as −0.0625 °C, giving 0/0.
  - 16'h0000 converts as 0/0.

## Structure
- Shared package `monitor_pkg` holds:
  - FSM state encoding.
  - Frame width (16).
  - Fractional bit count (4).
  - Saturation constants (TEMP_MAX=63, FRAC_MAX=15).
  - Monitor threshold constants.
- One sub-module, `spi_rx_shifter`, owns `sclk` generation, the half-period divider, the bit counter and the 16-bit shift register. It provides `start`/`done` to the parent.
- Conversion, saturation, fault check and period counter stay in the parent.

## Test plan
- Sensor model returns 16'h16C0 (45.5 °C) -> after 137 cycles, `valid` pulses once with `temp`=45, `temp_frac`=8; the frame has exactly 16 `sclk` rises.
- Frame 16'hFB00 (−10 °C) -> `temp`=0, `temp_frac`=0.
- Frame 16'h3200 (100 °C) -> `temp`=63, `temp_frac`=15.
- Frame 16'hFFFF -> with `TSR_FAULT_DETECT_EN`: `fault`=1, 63/15; next frame 16'h16C0 clears `fault`, giving 45/8. Without the macro: `fault`=0, 0/0.
- `rst_n` low for one cycle during bit 8 of SHIFT -> next edge shows `cs_n`=1, `sclk`=0, outputs 0, no `valid`; a new conversion starts the cycle after release.
- SAMPLE_PERIOD=200, CLK_DIV=2 -> `valid` pulses exactly 200 cycles apart over 5 conversions; `cs_n` high between frames.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared definitions for the thermal monitor front end: FSM encoding, frame
// geometry, saturation limits, monitor thresholds and the frame conversion.
package monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_UPDATE
  } tsr_state_t;

  localparam int FRAME_W   = 16;
  localparam int FRAC_BITS = 4;
  localparam int TEMP_W    = 6;

  localparam logic [TEMP_W-1:0]    TEMP_MAX = 6'd63;
  localparam logic [FRAC_BITS-1:0] FRAC_MAX = 4'd15;

  localparam logic [TEMP_W-1:0] TEMP_WARN = 6'd50;
  localparam logic [TEMP_W-1:0] TEMP_CRIT = 6'd60;

  typedef struct packed {
    logic [TEMP_W-1:0]    temp;
    logic [FRAC_BITS-1:0] frac;
  } reading_t;

  // Sensor word is a 13-bit signed value in frame[15:3]; clamp into 0..63.9375.
  function automatic reading_t convert_frame(input logic [FRAME_W-1:0] frame);
    logic [12:0] raw;
    reading_t    result;
    raw = frame[FRAME_W-1:3];
    if (raw[12]) begin
      result = '0;
    end else if (raw[11:10] != 2'b00) begin
      result.temp = TEMP_MAX;
      result.frac = FRAC_MAX;
    end else begin
      result.temp = raw[9:4];
      result.frac = raw[3:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// SPI receive engine: half-period divider, sclk generation (CPOL=0, CPHA=0),
// 15->0 bit counter and 16-bit shift register, driven by the reader FSM.
module spi_rx_shifter
  import monitor_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_busy,
  input  logic               i_shift,
  input  logic               i_miso,
  output logic               o_sclk,
  output logic               o_tick,
  output logic               o_done,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]      r_div;
  logic [3:0]         r_bit;
  logic               r_sclk;
  logic [FRAME_W-1:0] r_shift;

  assign o_tick  = (r_div == DW'(CLK_DIV - 1));
  assign o_done  = i_shift && o_tick && r_sclk && (r_bit == 4'd0);
  assign o_sclk  = r_sclk;
  assign o_frame = r_shift;

  // Data is captured on the same edge that raises sclk, i.e. the value the
  // sensor launched on the previous falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_bit   <= 4'd15;
      r_sclk  <= 1'b0;
      r_shift <= '0;
    end else if (i_start) begin
      r_div  <= '0;
      r_bit  <= 4'd15;
      r_sclk <= 1'b0;
    end else if (i_busy) begin
      r_div <= o_tick ? '0 : r_div + 1'b1;
      if (i_shift && o_tick) begin
        r_sclk <= ~r_sclk;
        if (!r_sclk) begin
          r_shift <= {r_shift[FRAME_W-2:0], i_miso};
        end else if (r_bit != 4'd0) begin
          r_bit <= r_bit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic SPI temperature reader producing saturated integer/sixteenth output.
// Optional fault detection (stuck-high/stuck-low frames) via TSR_FAULT_DETECT_EN.
module temp_sensor_reader
  import monitor_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 cs_n,
  output logic                 sclk,
  input  logic                 miso,
  output logic [TEMP_W-1:0]    temp,
  output logic [FRAC_BITS-1:0] temp_frac,
  output logic                 valid,
  output logic                 fault
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  tsr_state_t           r_state;
  tsr_state_t           w_nextState;
  logic [PW-1:0]        r_period;
  logic                 r_cs_n;
  logic [TEMP_W-1:0]    r_temp;
  logic [FRAC_BITS-1:0] r_frac;
  logic                 r_valid;
  logic                 w_start;
  logic                 w_busy;
  logic                 w_shift;
  logic                 w_load;
  logic                 w_tick;
  logic                 w_done;
  logic [FRAME_W-1:0]   w_frame;
  reading_t             w_reading;
  reading_t             w_result;

  assign w_start = (r_state == ST_IDLE) && (r_period == '0);

  spi_rx_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_busy  (w_busy),
    .i_shift (w_shift),
    .i_miso  (miso),
    .o_sclk  (sclk),
    .o_tick  (w_tick),
    .o_done  (w_done),
    .o_frame (w_frame)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_period <= '0;
      r_cs_n   <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_period <= (r_period == PW'(SAMPLE_PERIOD - 1)) ? '0 : r_period + 1'b1;
      r_cs_n   <= !((w_nextState == ST_SETUP) || (w_nextState == ST_SHIFT) ||
                    (w_nextState == ST_HOLD));
    end
  end

  // SETUP and HOLD each last one divider half-period; SHIFT ends on the
  // sixteenth falling sclk reported by the shifter.
  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_start) w_nextState = ST_SETUP;
      ST_SETUP: begin
        w_busy = 1'b1;
        if (w_tick) w_nextState = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_busy  = 1'b1;
        w_shift = 1'b1;
        if (w_done) w_nextState = ST_HOLD;
      end
      ST_HOLD: begin
        w_busy = 1'b1;
        if (w_tick) begin
          w_load      = 1'b1;
          w_nextState = ST_UPDATE;
        end
      end
      ST_UPDATE: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  assign w_reading = convert_frame(w_frame);

`ifdef TSR_FAULT_DETECT_EN
  logic w_badFrame;
  logic r_fault;

  assign w_badFrame = (w_frame == '1) || (w_frame == '0);

  // A dead sensor reads as full scale so the monitor fails safe into emergency.
  always_comb begin
    w_result = w_reading;
    if (w_badFrame) begin
      w_result.temp = TEMP_MAX;
      w_result.frac = FRAC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_load) begin
      r_fault <= w_badFrame;
    end
  end

  assign fault = r_fault;
`else
  assign w_result = w_reading;
  assign fault    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_temp  <= '0;
      r_frac  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_load;
      if (w_load) begin
        r_temp <= w_result.temp;
        r_frac <= w_result.frac;
      end
    end
  end

  assign cs_n      = r_cs_n;
  assign temp      = r_temp;
  assign temp_frac = r_frac;
  assign valid     = r_valid;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench: a CLK_DIV=4 reader fed by a sensor model for conversion,
// fault and reset cases, plus a CLK_DIV=2 / SAMPLE_PERIOD=200 reader for cadence.
module tb_temp_sensor_reader;

  localparam int DIV_A = 4;
  localparam int SP_A  = 300;
  localparam int DIV_B = 2;
  localparam int SP_B  = 200;
  localparam int LAT_A = 34 * DIV_A + 1;
  localparam int LAT_B = 34 * DIV_B + 1;

`ifdef TSR_FAULT_DETECT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  localparam logic [5:0] BAD_TEMP  = FAULT_EN ? 6'd63 : 6'd0;
  localparam logic [3:0] BAD_FRAC  = FAULT_EN ? 4'd15 : 4'd0;
  localparam logic       BAD_FAULT = FAULT_EN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA_n = 1'b0;
  logic       csA_n, sclkA, validA, faultA;
  logic       misoA = 1'b0;
  logic [5:0] tempA;
  logic [3:0] fracA;

  logic       rstB_n = 1'b0;
  logic       csB_n, sclkB, validB, faultB;
  logic       misoB = 1'b0;
  logic [5:0] tempB;
  logic [3:0] fracB;

  temp_sensor_reader #(.CLK_DIV(DIV_A), .SAMPLE_PERIOD(SP_A)) dutA (
    .clk(clk), .rst_n(rstA_n), .cs_n(csA_n), .sclk(sclkA), .miso(misoA),
    .temp(tempA), .temp_frac(fracA), .valid(validA), .fault(faultA)
  );

  temp_sensor_reader #(.CLK_DIV(DIV_B), .SAMPLE_PERIOD(SP_B)) dutB (
    .clk(clk), .rst_n(rstB_n), .cs_n(csB_n), .sclk(sclkB), .miso(misoB),
    .temp(tempB), .temp_frac(fracB), .valid(validB), .fault(faultB)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int risesA = 0;
  int risesAOut = 0;
  int risesB = 0;
  int lastValid = 0;
  int gap = 0;

  always @(posedge clk) cycle++;
  always @(posedge sclkA) begin
    risesA++;
    if (csA_n) risesAOut++;
  end
  always @(posedge sclkB) risesB++;

  // Sensor model: loads its word when selected and shifts on falling sclk.
  logic [15:0] sensorFrame = 16'h0000;
  logic [15:0] sensorShift = 16'h0000;
  bit          inFrame = 1'b0;
  always @(negedge csA_n or posedge csA_n or negedge sclkA) begin
    if (csA_n !== 1'b0) begin
      inFrame = 1'b0;
    end else if (!inFrame) begin
      inFrame     = 1'b1;
      sensorShift = sensorFrame;
    end else begin
      sensorShift = {sensorShift[14:0], 1'b0};
    end
    misoA = sensorShift[15];
  end

  task automatic waitValidA(input int budget, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < budget && !ok) begin
      @(posedge clk);
      #1;
      lat++;
      if (validA === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] frame, output bit ok);
    int lat;
    sensorFrame = frame;
    waitValidA(SP_A + 50, lat, ok);
    gap       = cycle - lastValid;
    lastValid = cycle;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({csA_n, sclkA, tempA, fracA, validA, faultA} !== {1'b1, 1'b0, 6'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got cs_n=%b sclk=%b temp=%0d frac=%0d valid=%b fault=%b, expected 1 0 0 0 0 0",
               csA_n, sclkA, tempA, fracA, validA, faultA);
    end
  endtask

  task automatic test_first_frame();
    int lat;
    bit ok;
    int r0;
    sensorFrame = 16'h16C0;
    r0 = risesA;
    @(negedge clk);
    rstA_n = 1'b1;
    waitValidA(SP_A, lat, ok);
    lastValid = cycle;
    checks++;
    if (!ok || lat != LAT_A) begin
      errors++;
      $display("[TB] FAIL first_latency: got %0d (seen=%0d) expected %0d", lat, ok, LAT_A);
    end
    checks++;
    if (tempA !== 6'd45 || fracA !== 4'd8) begin
      errors++;
      $display("[TB] FAIL first_value: got %0d/%0d expected 45/8", tempA, fracA);
    end
    checks++;
    if (risesA - r0 != 16) begin
      errors++;
      $display("[TB] FAIL first_sclk_rises: got %0d expected 16", risesA - r0);
    end
    checks++;
    if (csA_n !== 1'b1 || faultA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_cs_fault: got cs_n=%b fault=%b expected 1 0", csA_n, faultA);
    end
    @(posedge clk);
    #1;
    checks++;
    if (validA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL valid_one_cycle: got %b expected 0", validA);
    end
  endtask

  task automatic test_negative();
    bit ok;
    applyStimulus(16'hFB00, ok);
    checks++;
    if (!ok || tempA !== 6'd0 || fracA !== 4'd0 || faultA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL negative: got %0d/%0d fault=%b seen=%0d expected 0/0 fault=0", tempA, fracA, faultA, ok);
    end
    checks++;
    if (gap != SP_A) begin
      errors++;
      $display("[TB] FAIL period_a: got %0d expected %0d", gap, SP_A);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    applyStimulus(16'h3200, ok);
    checks++;
    if (!ok || tempA !== 6'd63 || fracA !== 4'd15 || faultA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturate_high: got %0d/%0d fault=%b seen=%0d expected 63/15 fault=0", tempA, fracA, faultA, ok);
    end
  endtask

  task automatic test_fault();
    bit ok;
    applyStimulus(16'h0000, ok);
    checks++;
    if (!ok || tempA !== BAD_TEMP || fracA !== BAD_FRAC || faultA !== BAD_FAULT) begin
      errors++;
      $display("[TB] FAIL stuck_low: got %0d/%0d fault=%b expected %0d/%0d fault=%b", tempA, fracA, faultA, BAD_TEMP, BAD_FRAC, BAD_FAULT);
    end
    applyStimulus(16'hFFFF, ok);
    checks++;
    if (!ok || tempA !== BAD_TEMP || fracA !== BAD_FRAC || faultA !== BAD_FAULT) begin
      errors++;
      $display("[TB] FAIL stuck_high: got %0d/%0d fault=%b expected %0d/%0d fault=%b", tempA, fracA, faultA, BAD_TEMP, BAD_FRAC, BAD_FAULT);
    end
    applyStimulus(16'h16C0, ok);
    checks++;
    if (!ok || tempA !== 6'd45 || fracA !== 4'd8 || faultA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_clear: got %0d/%0d fault=%b expected 45/8 fault=0", tempA, fracA, faultA);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int r0;
    int r1;
    int lat;
    bit ok;
    sensorFrame = 16'h16C0;
    r0 = risesA;
    n  = 0;
    while (risesA - r0 < 8 && n < SP_A + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (risesA - r0 < 8) begin
      errors++;
      $display("[TB] FAIL reach_bit8: got %0d rises expected 8", risesA - r0);
    end
    @(negedge clk);
    rstA_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({csA_n, sclkA, tempA, fracA, validA, faultA} !== {1'b1, 1'b0, 6'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got cs_n=%b sclk=%b temp=%0d frac=%0d valid=%b fault=%b, expected 1 0 0 0 0 0",
               csA_n, sclkA, tempA, fracA, validA, faultA);
    end
    r1 = risesA;
    @(negedge clk);
    rstA_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (csA_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_cs: got cs_n=%b expected 0", csA_n);
    end
    waitValidA(SP_A, lat, ok);
    checks++;
    if (!ok || lat + 1 != LAT_A || tempA !== 6'd45 || fracA !== 4'd8 || risesA - r1 != 16) begin
      errors++;
      $display("[TB] FAIL restart_frame: got latency=%0d value=%0d/%0d rises=%0d expected %0d 45/8 16",
               lat + 1, tempA, fracA, risesA - r1, LAT_A);
    end
    checks++;
    if (risesAOut != 0) begin
      errors++;
      $display("[TB] FAIL sclk_outside_frame: got %0d expected 0", risesAOut);
    end
  endtask

  task automatic test_period();
    int vcount = 0;
    int vcyc[5] = '{default: 0};
    int lowPer[5] = '{default: 0};
    int lowCount = 0;
    int n = 0;
    int r0;
    r0 = risesB;
    @(negedge clk);
    rstB_n = 1'b1;
    while (vcount < 5 && n < LAT_B + 4 * SP_B + 50) begin
      @(posedge clk);
      #1;
      n++;
      if (csB_n === 1'b0) lowCount++;
      if (validB === 1'b1) begin
        vcyc[vcount]   = n;
        lowPer[vcount] = lowCount;
        lowCount       = 0;
        vcount++;
      end
    end
    checks++;
    if (vcount != 5 || vcyc[0] != LAT_B) begin
      errors++;
      $display("[TB] FAIL period_b_start: got %0d pulses first at %0d expected 5 first at %0d", vcount, vcyc[0], LAT_B);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (vcyc[i] - vcyc[i-1] != SP_B) begin
        errors++;
        $display("[TB] FAIL period_b_gap%0d: got %0d expected %0d", i, vcyc[i] - vcyc[i-1], SP_B);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (lowPer[i] != 34 * DIV_B) begin
        errors++;
        $display("[TB] FAIL period_b_cs_low%0d: got %0d expected %0d", i, lowPer[i], 34 * DIV_B);
      end
    end
    checks++;
    if (risesB - r0 != 80 || tempB !== BAD_TEMP || fracB !== BAD_FRAC || faultB !== BAD_FAULT) begin
      errors++;
      $display("[TB] FAIL period_b_data: got rises=%0d value=%0d/%0d fault=%b expected 80 %0d/%0d fault=%b",
               risesB - r0, tempB, fracB, faultB, BAD_TEMP, BAD_FRAC, BAD_FAULT);
    end
  endtask

  initial begin
    $display("[TB] starting temp_sensor_reader bench (fault detect %0d)", FAULT_EN);
    test_reset();
    test_first_frame();
    test_negative();
    test_saturate();
    test_fault();
    test_reset_midframe();
    test_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
